seg_disp_arbiter: RTL and testbench
===================================

// Module: seg_disp_arbiter
// PURPOSE
//  Shares the 8-digit seven-segment display between three requesters: the CPU MMIO
//  display register, a debug snapshot (e.g. PC on button press) and the exception/error code.
//  Fixed priority: exception > debug > CPU. Debug snapshots stay up for a programmed hold time.
//  Output feeds the display scanner's data/base inputs; disp_blank gates its digit enables.
// PARAMETERS
//  HOLD_CYC   50_000_000  cycles a debug snapshot is shown (legal range >= 1)
//  BLINK_CYC  25_000_000  half-period of exception blink, in cycles (legal range >= 1)
// PORTS
//  clk        in   1   system clock
//  rstn       in   1   reset, asynchronous, active-low
//  cpu_we     in   1   1-cycle write strobe from CPU MMIO
//  cpu_wdata  in   32  CPU display value
//  cpu_base   in   1   CPU radix: 1 = decimal, 0 = hex
//  dbg_req    in   1   debug snapshot request, level; held until dbg_ack
//  dbg_data   in   32  debug value, hex radix; sampled when the request is accepted
//  dbg_ack    out  1   1-cycle pulse: request accepted and dbg_data latched
//  exc_req    in   1   exception active, level
//  exc_code   in   32  exception code, hex radix
//  disp_data  out  32  value to display
//  disp_base  out  1   radix to display
//  disp_src   out  2   0 = CPU, 1 = debug, 2 = exception
//  disp_blank out  1   1 = blank all digits (exception blink phase)
// BEHAVIOUR
//  Reset (async, rstn=0)
//   - state S_CPU; cpu_reg=0, cpu_base_reg=0, dbg_reg=0, exc_reg=0, hold_cnt=0, blink_cnt=0.
//   - Outputs: disp_data=0, disp_base=0, disp_src=0, disp_blank=0, dbg_ack=0.
//   - Reset mid-operation aborts any hold or blink. No state survives reset.
//  CPU register
//   - cpu_we=1 at edge k: cpu_reg/cpu_base_reg load cpu_wdata/cpu_base. This happens in every state.
//  Output timing
//   - All outputs are registered. They are computed from next-state and next-register values.
//   - Effect of inputs sampled at edge k is visible on the outputs right after edge k.
//  Debug accept
//   - Condition: dbg_req=1, dbg_ack=0, exc_req=0, state S_CPU or S_DBG.
//   - On accept: dbg_reg<=dbg_data, dbg_ack=1 for exactly 1 cycle, hold_cnt<=HOLD_CYC-1, state<=S_DBG.
//   - Accept in S_DBG restarts the hold time.
//  State transitions (evaluated in priority order)
//   - Any state, exc_req=1: go to / stay in S_EXC; exc_reg<=exc_code every cycle; no dbg accept.
//   - S_EXC, exc_req=0: go to S_CPU. An interrupted debug snapshot is discarded, not resumed.
//   - S_DBG, no accept, hold_cnt!=0: hold_cnt decrements.
//   - S_DBG, no accept, hold_cnt==0: go to S_CPU. Debug is displayed for exactly HOLD_CYC cycles.
//  Output mux
//   - S_CPU: disp_data=cpu_reg, disp_base=cpu_base_reg, disp_src=0.
//   - S_DBG: disp_data=dbg_reg, disp_base=0, disp_src=1.
//   - S_EXC: disp_data=exc_reg, disp_base=0, disp_src=2.
//  Blink
//   - On entry to S_EXC: blink_cnt=0, disp_blank=0.
//   - disp_blank toggles after every BLINK_CYC cycles in S_EXC.
//   - disp_blank=0 and blink_cnt=0 in all other states.
//  Boundary and simultaneous events
//   - exc_req and dbg_req in the same cycle: exception wins; no ack; the request stays pending.
//   - cpu_we during S_DBG/S_EXC: captured silently; shown on return to S_CPU.
//   - dbg_req still high in the cycle after ack: not re-accepted (dbg_ack=1 blocks it).
//     It is accepted again the following cycle if still high.
//   - HOLD_CYC=1: debug is shown for 1 cycle.
//   - Counter widths: $clog2(HOLD_CYC+1) and $clog2(BLINK_CYC+1); no wrap beyond the terminal value.
// TESTING (HOLD_CYC=8, BLINK_CYC=4)
//  1 Reset release, cpu_we with 0x0000_1234 base=1 -> disp_data=0x1234, disp_base=1, disp_src=0 after that edge.
//  2 dbg_req=1 with 0xDEAD_BEEF in S_CPU -> dbg_ack 1 cycle; disp_src=1 for 8 cycles,
//    then disp_src=0 with CPU value; cpu_we during the hold is shown afterwards.
//  3 exc_req=1 mid-debug with code 0x0000_000B -> next edge disp_src=2, base=0;
//    disp_blank 0,0,0,0,1,1,1,1,...; drop exc_req -> disp_src=0 (debug not resumed).
//  4 exc_req and dbg_req asserted together, exc for 3 cycles -> no ack during exc;
//    ack in the first cycle after exc_req=0 -> S_DBG.
//  5 dbg_req held high 20 cycles -> acks spaced by 2 cycles; hold keeps restarting; disp_src stays 1.
//  6 rstn pulsed low mid S_EXC blink -> all outputs 0 immediately (async); S_CPU after release.

Source files
------------

// File: rtl/seg_disp_arbiter.sv
// seg_disp_arbiter
//   Shares the 8-digit seven-segment display between three sources: the CPU
//   MMIO display register, a debug snapshot (shown for HOLD_CYC cycles) and
//   the exception code (blinking with half-period BLINK_CYC).
//   Fixed priority: exception > debug > CPU. All outputs are registered and
//   are computed from the next-state / next-register values, so an input
//   sampled at an edge is visible on the outputs right after that edge.
// Ports
//   clk, rstn             clock, asynchronous active-low reset
//   cpu_we/wdata/base     CPU display register write (1-cycle strobe)
//   dbg_req/data, dbg_ack debug snapshot handshake (level request, 1-cycle ack)
//   exc_req/exc_code      exception active (level) and its code
//   disp_data/base/src    value, radix and source selected for the scanner
//   disp_blank            blanks all digits during the exception blink-off phase
module seg_disp_arbiter #(
  parameter int HOLD_CYC  = 50_000_000,
  parameter int BLINK_CYC = 25_000_000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cpu_we,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_base,
  input  logic        dbg_req,
  input  logic [31:0] dbg_data,
  output logic        dbg_ack,
  input  logic        exc_req,
  input  logic [31:0] exc_code,
  output logic [31:0] disp_data,
  output logic        disp_base,
  output logic [1:0]  disp_src,
  output logic        disp_blank
);

  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam int BW = $clog2(BLINK_CYC + 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYC - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYC - 1);

  // Encoding doubles as the disp_src code.
  typedef enum logic [1:0] {
    S_CPU = 2'd0,
    S_DBG = 2'd1,
    S_EXC = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   cpu_reg_q, cpu_reg_d;
  logic          cpu_base_q, cpu_base_d;
  logic [31:0]   dbg_reg_q, dbg_reg_d;
  logic [31:0]   exc_reg_q, exc_reg_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [BW-1:0] blink_q, blink_d;
  logic          blank_q, blank_d;
  logic          ack_q, ack_d;
  logic [31:0]   data_q, data_d;
  logic          base_q, base_d;
  logic          accept;

  // The registered ack blocks an immediate re-accept of a still-high request.
  assign accept = dbg_req && !ack_q && !exc_req &&
                  (state_q == S_CPU || state_q == S_DBG);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_CPU;
      cpu_reg_q  <= '0;
      cpu_base_q <= 1'b0;
      dbg_reg_q  <= '0;
      exc_reg_q  <= '0;
      hold_q     <= '0;
      blink_q    <= '0;
      blank_q    <= 1'b0;
      ack_q      <= 1'b0;
      data_q     <= '0;
      base_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cpu_reg_q  <= cpu_reg_d;
      cpu_base_q <= cpu_base_d;
      dbg_reg_q  <= dbg_reg_d;
      exc_reg_q  <= exc_reg_d;
      hold_q     <= hold_d;
      blink_q    <= blink_d;
      blank_q    <= blank_d;
      ack_q      <= ack_d;
      data_q     <= data_d;
      base_q     <= base_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cpu_reg_d  = cpu_reg_q;
    cpu_base_d = cpu_base_q;
    dbg_reg_d  = dbg_reg_q;
    exc_reg_d  = exc_reg_q;
    hold_d     = hold_q;
    blink_d    = '0;
    blank_d    = 1'b0;
    ack_d      = accept;
    data_d     = '0;
    base_d     = 1'b0;

    // The CPU register keeps tracking writes regardless of who owns the display.
    if (cpu_we) begin
      cpu_reg_d  = cpu_wdata;
      cpu_base_d = cpu_base;
    end

    if (exc_req) begin
      state_d   = S_EXC;
      exc_reg_d = exc_code;
      hold_d    = '0;
    end else if (accept) begin
      state_d   = S_DBG;
      dbg_reg_d = dbg_data;
      hold_d    = HOLD_LAST;
    end else begin
      case (state_q)
        S_EXC: begin
          // An interrupted snapshot is dropped, not resumed.
          state_d = S_CPU;
          hold_d  = '0;
        end
        S_DBG: begin
          if (hold_q != '0) begin
            hold_d = hold_q - HW'(1);
          end else begin
            state_d = S_CPU;
          end
        end
        default: begin
          state_d = S_CPU;
        end
      endcase
    end

    // Blink phase restarts (visible) on every entry into S_EXC.
    if (state_d == S_EXC && state_q == S_EXC) begin
      if (blink_q == BLINK_LAST) begin
        blink_d = '0;
        blank_d = ~blank_q;
      end else begin
        blink_d = blink_q + BW'(1);
        blank_d = blank_q;
      end
    end

    case (state_d)
      S_DBG:   data_d = dbg_reg_d;
      S_EXC:   data_d = exc_reg_d;
      default: begin
        data_d = cpu_reg_d;
        base_d = cpu_base_d;
      end
    endcase
  end

  assign dbg_ack    = ack_q;
  assign disp_data  = data_q;
  assign disp_base  = base_q;
  assign disp_src   = state_q;
  assign disp_blank = blank_q;

endmodule

// File: tb/tb_seg_disp_arbiter.sv
module tb_seg_disp_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cpu_we;
  logic [31:0] cpu_wdata;
  logic        cpu_base;
  logic        dbg_req;
  logic [31:0] dbg_data;
  logic        dbg_ack;
  logic        exc_req;
  logic [31:0] exc_code;
  logic [31:0] disp_data;
  logic        disp_base;
  logic [1:0]  disp_src;
  logic        disp_blank;

  int checks   = 0;
  int failures = 0;

  seg_disp_arbiter #(.HOLD_CYC(8), .BLINK_CYC(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .cpu_we     (cpu_we),
    .cpu_wdata  (cpu_wdata),
    .cpu_base   (cpu_base),
    .dbg_req    (dbg_req),
    .dbg_data   (dbg_data),
    .dbg_ack    (dbg_ack),
    .exc_req    (exc_req),
    .exc_code   (exc_code),
    .disp_data  (disp_data),
    .disp_base  (disp_base),
    .disp_src   (disp_src),
    .disp_blank (disp_blank)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] wd;
    logic        wb;
    logic        dr;
    logic [31:0] dd;
    logic [31:0] e_data;
    logic        e_base;
    logic [1:0]  e_src;
    logic        e_ack;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input logic we, input logic [31:0] wd, input logic wb,
                              input logic dr, input logic [31:0] dd,
                              input logic [31:0] e_data, input logic e_base,
                              input logic [1:0] e_src, input logic e_ack);
    vec_t v;
    v.we = we; v.wd = wd; v.wb = wb; v.dr = dr; v.dd = dd;
    v.e_data = e_data; v.e_base = e_base; v.e_src = e_src; v.e_ack = e_ack;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are checked at the next falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_all(input string tag, input logic [31:0] d, input logic b,
                         input logic [1:0] s, input logic bl, input logic a);
    chk({tag, ".data"},  disp_data,          d);
    chk({tag, ".base"},  32'(disp_base),     32'(b));
    chk({tag, ".src"},   32'(disp_src),      32'(s));
    chk({tag, ".blank"}, 32'(disp_blank),    32'(bl));
    chk({tag, ".ack"},   32'(dbg_ack),       32'(a));
  endtask

  initial begin
    rstn = 1'b0; cpu_we = 1'b0; cpu_wdata = '0; cpu_base = 1'b0;
    dbg_req = 1'b0; dbg_data = '0; exc_req = 1'b0; exc_code = '0;

    // CPU write, then a debug snapshot with a CPU write during the hold.
    vecs[0]  = mk(1, 32'h0000_1234, 1, 0, 32'h0,         32'h0000_1234, 1, 2'd0, 0);
    vecs[1]  = mk(0, 32'h0,         0, 0, 32'h0,         32'h0000_1234, 1, 2'd0, 0);
    vecs[2]  = mk(0, 32'h0,         0, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 2'd1, 1);
    vecs[3]  = mk(0, 32'h0,         0, 0, 32'h0,         32'hDEAD_BEEF, 0, 2'd1, 0);
    vecs[4]  = mk(1, 32'h0000_5678, 0, 0, 32'h0,         32'hDEAD_BEEF, 0, 2'd1, 0);
    vecs[5]  = mk(0, 32'h0,         0, 0, 32'h0,         32'hDEAD_BEEF, 0, 2'd1, 0);
    vecs[6]  = mk(0, 32'h0,         0, 0, 32'h0,         32'hDEAD_BEEF, 0, 2'd1, 0);
    vecs[7]  = mk(0, 32'h0,         0, 0, 32'h0,         32'hDEAD_BEEF, 0, 2'd1, 0);
    vecs[8]  = mk(0, 32'h0,         0, 0, 32'h0,         32'hDEAD_BEEF, 0, 2'd1, 0);
    vecs[9]  = mk(0, 32'h0,         0, 0, 32'h0,         32'hDEAD_BEEF, 0, 2'd1, 0);
    vecs[10] = mk(0, 32'h0,         0, 0, 32'h0,         32'h0000_5678, 0, 2'd0, 0);
    vecs[11] = mk(1, 32'h0000_0099, 1, 0, 32'h0,         32'h0000_0099, 1, 2'd0, 0);

    // Reset state
    step();
    chk_all("reset", 32'h0, 1'b0, 2'd0, 1'b0, 1'b0);
    rstn = 1'b1;

    // Table: CPU write and debug hold of exactly 8 cycles
    for (int i = 0; i < 12; i++) begin
      cpu_we = vecs[i].we; cpu_wdata = vecs[i].wd; cpu_base = vecs[i].wb;
      dbg_req = vecs[i].dr; dbg_data = vecs[i].dd;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_base, vecs[i].e_src, 1'b0, vecs[i].e_ack);
    end
    cpu_we = 1'b0;

    // Exception interrupts a debug snapshot; blink pattern; no resume
    dbg_req = 1'b1; dbg_data = 32'h0000_1111;
    step();
    chk_all("exc_pre_ack", 32'h0000_1111, 1'b0, 2'd1, 1'b0, 1'b1);
    dbg_req = 1'b0;
    step();
    step();
    chk("exc_pre_src", 32'(disp_src), 32'd1);
    exc_req = 1'b1; exc_code = 32'h0000_000B;
    step();
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin
        if (i == 6) exc_code = 32'h0000_000C;
        step();
      end
      chk_all($sformatf("blink%0d", i), (i < 6) ? 32'h0000_000B : 32'h0000_000C,
              1'b0, 2'd2, 1'((i / 4) % 2), 1'b0);
    end
    exc_req = 1'b0;
    step();
    chk_all("exc_exit", 32'h0000_0099, 1'b1, 2'd0, 1'b0, 1'b0);
    step();
    chk_all("exc_noresume", 32'h0000_0099, 1'b1, 2'd0, 1'b0, 1'b0);

    // Simultaneous exception and debug request: exception wins, request stays pending
    exc_req = 1'b1; exc_code = 32'h0000_000E; dbg_req = 1'b1; dbg_data = 32'h0000_2222;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all($sformatf("simul_exc%0d", i), 32'h0000_000E, 1'b0, 2'd2, 1'b0, 1'b0);
    end
    exc_req = 1'b0;
    step();
    chk_all("simul_leave", 32'h0000_0099, 1'b1, 2'd0, 1'b0, 1'b0);
    step();
    chk_all("simul_ack", 32'h0000_2222, 1'b0, 2'd1, 1'b0, 1'b1);
    dbg_req = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("simul_hold_end", 32'(disp_src), 32'd0);

    // Debug request held high: acks every other cycle, hold keeps restarting
    dbg_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      dbg_data = 32'h0000_3000 + 32'(i);
      step();
      chk_all($sformatf("held%0d", i), 32'h0000_3000 + 32'(i - (i % 2)),
              1'b0, 2'd1, 1'b0, 1'((i % 2) == 0));
    end
    dbg_req = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("held_last_cycle", 32'(disp_src), 32'd1);
    step();
    chk("held_done", 32'(disp_src), 32'd0);

    // Asynchronous reset in the middle of the blink-off phase
    exc_req = 1'b1; exc_code = 32'h0000_00AA;
    step();
    for (int i = 0; i < 5; i++) step();
    chk("rst_pre_blank", 32'(disp_blank), 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk_all("rst_async", 32'h0, 1'b0, 2'd0, 1'b0, 1'b0);
    exc_req = 1'b0;
    step();
    chk_all("rst_held", 32'h0, 1'b0, 2'd0, 1'b0, 1'b0);
    rstn = 1'b1;
    step();
    chk_all("rst_release", 32'h0, 1'b0, 2'd0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
